// File: rtl/wr_arbiter.sv
// Round-robin write-port arbiter with bounded burst ownership for the async FIFO write side.
// Define WR_ARB_STATS_EN to add per-requester accepted/stall counters on stat_sel/stat_cnt.
module wr_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic           wclk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   w_data,
  output logic           winc,
  input  logic           wfull,
  output logic [2:0]     owner,
`ifdef WR_ARB_STATS_EN
  input  logic [2:0]     stat_sel,
  output logic [15:0]    stat_cnt,
`endif
  output logic           busy
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e     state_q, state_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] owner_q, owner_d;
  logic [3:0] beat_q, beat_d;

  logic [7:0]   req_pad;
  logic [7:0]   gnt_pad;
  logic [W-1:0] data_arr [8];
  logic [2:0]   sel, cur;
  logic         found, wr;

  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i == 3'(N - 1)) ? 3'd0 : i + 3'd1;
  endfunction

  // Pad to 8 lanes so a 3-bit index is always in range.
  always_comb begin
    req_pad = 8'(req);
    for (int i = 0; i < 8; i++) data_arr[i] = '0;
    for (int i = 0; i < N; i++) data_arr[i] = req_data[i*W +: W];
  end

  always_comb begin
    logic [3:0] tmp;
    sel   = rr_ptr_q;
    found = 1'b0;
    tmp   = '0;
    for (int k = 0; k < N; k++) begin
      tmp = {1'b0, rr_ptr_q} + 4'(k);
      if (tmp >= 4'(N)) tmp = tmp - 4'(N);
      if (!found && req_pad[tmp[2:0]]) begin
        sel   = tmp[2:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    cur      = owner_q;
    wr       = 1'b0;
    unique case (state_q)
      StIdle: begin
        cur = sel;
        if (found) begin
          owner_d = sel;
          state_d = StBurst;
          if (!wfull) begin
            wr     = 1'b1;
            beat_d = 4'd1;
            if (MAX_BURST == 1) begin
              state_d  = StIdle;
              rr_ptr_d = next_idx(sel);
              beat_d   = 4'd0;
            end
          end
        end
      end
      StBurst: begin
        wr = req_pad[owner_q] & ~wfull;
        if (!req_pad[owner_q] || (wr && (beat_q + 4'd1 == 4'(MAX_BURST)))) begin
          state_d  = StIdle;
          rr_ptr_d = next_idx(owner_q);
          beat_d   = 4'd0;
        end else if (wr) begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= 3'd0;
      owner_q  <= 3'd0;
      beat_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
    end
  end

  // Outputs are forced low while reset is held, independent of req/wfull.
  always_comb begin
    winc    = wr & rst;
    gnt_pad = winc ? (8'd1 << cur) : 8'd0;
    gnt     = gnt_pad[N-1:0];
    w_data  = winc ? data_arr[cur] : '0;
    busy    = rst & (state_q == StBurst);
    owner   = owner_q;
  end

`ifdef WR_ARB_STATS_EN
  logic [15:0] acc_q   [N];
  logic [15:0] stall_q [N];
  logic        stall;

  // A stall is a cycle where the current contender wants to write but the FIFO is full.
  assign stall = rst & wfull & req_pad[cur];

  always_ff @(posedge wclk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        acc_q[i]   <= 16'd0;
        stall_q[i] <= 16'd0;
      end else begin
        if (gnt_pad[i]) acc_q[i] <= acc_q[i] + 16'd1;
        if (stall && (cur == 3'(i))) stall_q[i] <= stall_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_cnt = 16'd0;
    for (int i = 0; i < N; i++) begin
      if (stat_sel[2] && (N <= 4)) begin
        if ({1'b0, stat_sel[1:0]} == 3'(i)) stat_cnt = stall_q[i];
      end else if (stat_sel == 3'(i)) begin
        stat_cnt = acc_q[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_wr_arbiter.sv
// Directed self-checking bench for wr_arbiter (N=4, W=8, MAX_BURST=4) with a FIFO pairing phase.
module tb_wr_arbiter;

  logic        wclk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  w_data;
  logic        winc;
  logic        wfull;
  logic [2:0]  owner;
  logic        busy;
  logic [2:0]  stat_sel;
  logic [15:0] stat_cnt;

  int vectors     = 0;
  int miscompares = 0;

  wr_arbiter #(.N(4), .W(8), .MAX_BURST(4)) dut (
    .wclk     (wclk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .w_data   (w_data),
    .winc     (winc),
    .wfull    (wfull),
    .owner    (owner),
`ifdef WR_ARB_STATS_EN
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt),
`endif
    .busy     (busy)
  );

`ifndef WR_ARB_STATS_EN
  assign stat_cnt = 16'd0;
`endif

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int nxt[4];
    int exp_rx[4];
    logic [7:0] fifo[$];
    int rx, v, r;

    rst      = 1'b0;
    req      = 4'b1111;
    wfull    = 1'b0;
    stat_sel = 3'd0;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'hA0 + 8'(i);

    // Reset held with all requests pending
    for (int c = 0; c < 3; c++) begin
      @(negedge wclk); #1;
      chk("rst_winc", winc, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_wdata", w_data, 0);
      chk("rst_busy", busy, 0);
    end
    chk("rst_owner", owner, 0);

    // Fairness: four beats per requester in rotation
    for (int c = 0; c < 32; c++) begin
      @(negedge wclk);
      rst = 1'b1;
      #1;
      chk("fair_gnt", gnt, 32'(1) << ((c / 4) % 4));
      chk("fair_wdata", w_data, 32'hA0 + 32'((c / 4) % 4));
      chk("fair_winc", winc, 1);
    end
    @(negedge wclk);
    req = 4'b0000;
`ifdef WR_ARB_STATS_EN
    for (int s = 0; s < 4; s++) begin
      @(negedge wclk);
      stat_sel = 3'(s);
      #1;
      chk("stat_acc", stat_cnt, 8);
    end
    @(negedge wclk);
    stat_sel = 3'd4;
    #1;
    chk("stat_stall0", stat_cnt, 0);
`endif

    // Early release by requester 2, then rr_ptr=3 favours requester 3 over 0
    @(negedge wclk); req = 4'b0100; #1;
    chk("early_gnt0", gnt, 4'b0100);
    @(negedge wclk); #1;
    chk("early_gnt1", gnt, 4'b0100);
    chk("early_busy", busy, 1);
    @(negedge wclk); req = 4'b0000; #1;
    chk("early_drop_gnt", gnt, 0);
    chk("early_drop_wdata", w_data, 0);
    chk("early_drop_busy", busy, 1);
    @(negedge wclk); req = 4'b1001; #1;
    chk("early_r3_first", gnt, 4'b1000);
    for (int c = 0; c < 3; c++) begin
      @(negedge wclk); #1;
      chk("early_r3_burst", gnt, 4'b1000);
      chk("early_r3_owner", owner, 3);
    end
    @(negedge wclk); #1;
    chk("early_r0_next", gnt, 4'b0001);
    @(negedge wclk); req = 4'b0000; #1;
    chk("early_end_gnt", gnt, 0);

    // Full stall of owner 1 after two beats
    @(negedge wclk); req = 4'b1111; #1;
    chk("stall_pre0", gnt, 4'b0010);
    @(negedge wclk); #1;
    chk("stall_pre1", gnt, 4'b0010);
    for (int c = 0; c < 5; c++) begin
      @(negedge wclk); wfull = 1'b1; #1;
      chk("stall_winc", winc, 0);
      chk("stall_gnt", gnt, 0);
      chk("stall_owner", owner, 1);
      chk("stall_busy", busy, 1);
    end
    @(negedge wclk); wfull = 1'b0; #1;
    chk("stall_post0", gnt, 4'b0010);
    @(negedge wclk); #1;
    chk("stall_post1", gnt, 4'b0010);
    @(negedge wclk); #1;
    chk("stall_rotate", gnt, 4'b0100);
`ifdef WR_ARB_STATS_EN
    stat_sel = 3'd5; #1;
    chk("stat_stall1", stat_cnt, 5);
    stat_sel = 3'd1; #1;
    chk("stat_acc1", stat_cnt, 12);
`endif

    // Reset in the middle of requester 2's burst
    @(negedge wclk); rst = 1'b0; #1;
    chk("midrst_winc", winc, 0);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_wdata", w_data, 0);
    chk("midrst_busy", busy, 0);
    @(negedge wclk); rst = 1'b1; #1;
    chk("midrst_regrant", gnt, 4'b0001);
    chk("midrst_idle", busy, 0);
`ifdef WR_ARB_STATS_EN
    chk("midrst_stat", stat_cnt, 0);
`endif
    @(negedge wclk); req = 4'b0000; #1;
    chk("midrst_drop", gnt, 0);

    // Pairing with a depth-4 FIFO model and random read pops
    for (int i = 0; i < 4; i++) begin
      nxt[i]    = 0;
      exp_rx[i] = 0;
    end
    rx = 0;
    for (int c = 0; c < 2000 && rx < 40; c++) begin
      @(negedge wclk);
      wfull = (fifo.size() >= 4);
      for (int i = 0; i < 4; i++) begin
        req[i] = (nxt[i] < 10);
        req_data[i*8 +: 8] = 8'(i * 10 + nxt[i] + 1);
      end
      #1;
      chk("fifo_no_full_write", 32'(winc & wfull), 0);
      chk("fifo_gnt_winc", 32'(gnt != 4'b0000), 32'(winc));
      if (winc) begin
        for (int i = 0; i < 4; i++) begin
          if (gnt[i]) begin
            chk("fifo_wdata", w_data, 32'(i * 10 + nxt[i] + 1));
            nxt[i]++;
          end
        end
      end
      if (fifo.size() > 0 && $urandom_range(1, 0) == 1) begin
        v = int'(fifo.pop_front());
        r = (v >= 1 && v <= 40) ? (v - 1) / 10 : 0;
        chk("fifo_order", 32'(v), 32'(r * 10 + exp_rx[r] + 1));
        exp_rx[r]++;
        rx++;
      end
      if (winc) fifo.push_back(w_data);
    end
    chk("fifo_count", 32'(rx), 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
